mem_req_sequencer: RTL and testbench
====================================

Name: mem_req_sequencer

Overview:
- Sits directly upstream of mem_system, between the pipeline memory stage and the cache/memory system.
- Accepts one load or store request per cycle from the pipeline.
- Buffers stores in a small FIFO so they retire without stalling the pipeline. Forwards buffered store data to matching loads.
- Presents exactly one Rd or Wr to mem_system at a time and holds address, data and strobe stable until Done.

Parameters:
- STB_DEPTH, 2, number of store-buffer entries (power of two, 2..8).
- PTR_W, 1, log2(STB_DEPTH); width of the head/tail pointers.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline request present.
- req_rd  in  1  request is a load.
- req_wr  in  1  request is a store.
- req_addr  in  16  byte address; must be word-aligned.
- req_wdata  in  16  store data.
- req_stall  out  1  request not accepted this cycle; pipeline holds its inputs.
- rsp_valid  out  1  one-cycle pulse; load data or error is valid.
- rsp_data  out  16  load data.
- rsp_err  out  1  with rsp_valid: misaligned or illegal request, or memory error on a load.
- err_sticky  out  1  set by any memory error during a store drain; cleared only by rst.
- stb_empty  out  1  store buffer empty and no access outstanding; the halt/dump logic waits on this.
- mem_addr  out  16  to mem_system Addr.
- mem_wdata  out  16  to mem_system DataIn.
- mem_rd  out  1  to mem_system Rd.
- mem_wr  out  1  to mem_system Wr.
- mem_rdata  in  16  from mem_system DataOut; valid when mem_done=1.
- mem_done  in  1  from mem_system Done.
- mem_stall  in  1  from mem_system Stall; informational only, no required effect.
- mem_err  in  1  from mem_system err.

Behaviour:
- Reset, asynchronous:
  - State is IDLE; store-buffer count, head and tail are 0.
  - All of mem_rd, mem_wr, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_err and err_sticky are 0.
  - stb_empty is 1.
  - Reset mid-access drops the outstanding access and all buffered stores.
- All mem_* outputs are registered. mem_rd or mem_wr is held high from issue through the cycle mem_done=1, and goes low the following cycle.
- States:
  - IDLE: no access outstanding.
  - LOAD: Rd outstanding.
  - DRAIN: Wr of the store-buffer head outstanding.
- Request classification, evaluated when req_valid=1:
  - Illegal: req_rd and req_wr both 1, both 0, or req_addr[0]=1. Accepted in any state with no stall. Produces rsp_valid=1, rsp_err=1 on the next cycle; no memory access.
  - Store accepted: count<STB_DEPTH, or (state=DRAIN and mem_done=1) when full. Written at the tail; no response.
  - Load accepted: only in IDLE.
- Load forwarding:
  - On a load, compare req_addr against all valid buffer entries.
  - On a match, the youngest matching entry supplies the data: rsp_valid=1, rsp_data=entry data, rsp_err=0 on the next cycle. State stays IDLE.
  - On no match: latch the address, go to LOAD, drive mem_rd=1 from the next cycle.
- LOAD exit: when mem_done=1, capture mem_rdata and mem_err. rsp_valid, rsp_data and rsp_err are presented on the next cycle; state returns to IDLE.
- Drain:
  - In IDLE with count>0 and no load accepted this cycle, go to DRAIN and drive the head entry on mem_addr/mem_wdata with mem_wr=1.
  - On mem_done=1: pop the head, OR mem_err into err_sticky, return to IDLE.
  - A pending load therefore has priority over the drain.
- req_stall is 1 when req_valid=1 and any of:
  - a load is presented while not in IDLE;
  - a load is presented in IDLE with a response pending;
  - a store is presented with the buffer full and no same-cycle pop.
- Same cycle store push and drain pop: count unchanged; the pointers wrap modulo STB_DEPTH.
- Forwarding never reads an entry that is popped in the same cycle unless it is still valid that cycle; compare uses pre-pop state.
- stb_empty = (count==0) and (state==IDLE).
- At most one rsp_valid per cycle; rsp_valid never coincides with req_stall for the same load.

Decomposition:
- Shared package: state encoding constants (IDLE, LOAD, DRAIN) and the word-alignment check constant.
- One natural sub-module: mem_store_buffer (FIFO plus parallel address-compare/youngest-match forward logic), parameterised by STB_DEPTH.

Test Plan:
- Store 0x0010 <- 0xBEEF with buffer empty -> no stall; mem_wr=1 with addr 0x0010, data 0xBEEF from cycle+2; held until mem_done; then stb_empty=1.
- Two stores, then a third while the first drain is outstanding with STB_DEPTH=2 -> third store stalls until mem_done, then is accepted the same cycle; entries drain in FIFO order.
- Store 0x0020 <- 0x1234, then load 0x0020 -> rsp_valid next cycle, rsp_data=0x1234, no mem_rd.
- Load 0x0040 with memory returning 0xCAFE after 4 cycles -> mem_rd held 4 cycles; rsp_valid=1, rsp_data=0xCAFE the cycle after mem_done; a pending store drain starts only afterwards.
- Load 0x0003 -> rsp_valid, rsp_err=1 next cycle. Load with req_rd=req_wr=1 -> same response. No memory access in either case.
- mem_err=1 with mem_done during a drain -> err_sticky=1 and remains 1. Assert rst during LOAD -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/mem_req_sequencer_pkg.sv
// Shared constants for the memory request sequencer: FSM state encoding and
// the word-alignment rule applied to every pipeline request.
package mem_req_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [15:0] WORD_ALIGN_MASK = 16'h0001;

    function automatic logic addr_misaligned(input logic [15:0] addr);
        return (addr & WORD_ALIGN_MASK) != 16'h0000;
    endfunction

endpackage

// File: rtl/mem_store_buffer.sv
// Circular store buffer with a parallel address compare that returns the data
// of the youngest valid entry matching the lookup address.
module mem_store_buffer
    import mem_req_sequencer_pkg::*;
#(
    parameter int STB_DEPTH = 2,
    parameter int PTR_W     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [15:0]      push_addr,
    input  logic [15:0]      push_data,
    input  logic             pop,
    input  logic [15:0]      lkp_addr,
    output logic             lkp_hit,
    output logic [15:0]      lkp_data,
    output logic [15:0]      head_addr,
    output logic [15:0]      head_data,
    output logic [PTR_W:0]   count
);

    logic [15:0]      addr_q [STB_DEPTH];
    logic [15:0]      data_q [STB_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] idx;

    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset: validity comes from count/head alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= push_addr;
            data_q[tail_q] <= push_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        lkp_hit  = 1'b0;
        lkp_data = '0;
        idx      = head_q;
        for (int i = 0; i < STB_DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) && (addr_q[idx] == lkp_addr)) begin
                lkp_hit  = 1'b1;
                lkp_data = data_q[idx];
            end
        end
    end

    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/mem_req_sequencer.sv
// Sequences pipeline loads/stores onto a single-outstanding memory port,
// buffering stores and forwarding buffered data to matching loads.
module mem_req_sequencer
    import mem_req_sequencer_pkg::*;
#(
    parameter int STB_DEPTH = 2,
    parameter int PTR_W     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_stall,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        err_sticky,
    output logic        stb_empty,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic        mem_err
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(STB_DEPTH);

    logic [1:0]     state_q, state_d;
    logic           mem_rd_q, mem_rd_d;
    logic           mem_wr_q, mem_wr_d;
    logic [15:0]    mem_addr_q, mem_addr_d;
    logic [15:0]    mem_wdata_q, mem_wdata_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [15:0]    rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;
    logic           err_sticky_q, err_sticky_d;
    logic           err_pend_q, err_pend_d;

    logic           illegal, is_ld, is_st;
    logic           ld_stall, st_stall, ld_acc, st_acc;
    logic           drain_pop, stb_full, data_rsp;
    logic           fwd_hit;
    logic [15:0]    fwd_data, head_addr, head_data;
    logic [PTR_W:0] stb_count;
    logic           unused_mem_stall;

    assign unused_mem_stall = mem_stall;

    assign illegal   = req_valid && ((req_rd == req_wr) || addr_misaligned(req_addr));
    assign is_ld     = req_valid && !illegal && req_rd;
    assign is_st     = req_valid && !illegal && req_wr;
    assign drain_pop = (state_q == ST_DRAIN) && mem_done;
    assign stb_full  = (stb_count == FULL_CNT);

    // err_pend_q marks an error response deferred behind a load response.
    assign ld_stall  = is_ld && ((state_q != ST_IDLE) || err_pend_q);
    assign st_stall  = is_st && stb_full && !drain_pop;
    assign ld_acc    = is_ld && !ld_stall;
    assign st_acc    = is_st && !st_stall;
    assign req_stall = ld_stall || st_stall;

    mem_store_buffer #(
        .STB_DEPTH (STB_DEPTH),
        .PTR_W     (PTR_W)
    ) u_stb (
        .clk       (clk),
        .rst       (rst),
        .push      (st_acc),
        .push_addr (req_addr),
        .push_data (req_wdata),
        .pop       (drain_pop),
        .lkp_addr  (req_addr),
        .lkp_hit   (fwd_hit),
        .lkp_data  (fwd_data),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (stb_count)
    );

    always_comb begin
        state_d      = state_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        err_sticky_d = err_sticky_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_acc && !fwd_hit) begin
                    state_d    = ST_LOAD;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = req_addr;
                end else if (!ld_acc && (stb_count != '0)) begin
                    state_d     = ST_DRAIN;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = head_addr;
                    mem_wdata_d = head_data;
                end
            end
            ST_LOAD: begin
                if (mem_done) begin
                    state_d  = ST_IDLE;
                    mem_rd_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (mem_done) begin
                    state_d      = ST_IDLE;
                    mem_wr_d     = 1'b0;
                    err_sticky_d = err_sticky_q | mem_err;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Load data responses win the single response slot; error responses queue.
    assign data_rsp = ((state_q == ST_LOAD) && mem_done) || (ld_acc && fwd_hit);

    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        err_pend_d  = 1'b0;
        if (data_rsp) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = (state_q == ST_LOAD) ? mem_rdata : fwd_data;
            rsp_err_d   = (state_q == ST_LOAD) && mem_err;
            err_pend_d  = err_pend_q || illegal;
        end else if (err_pend_q) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            err_pend_d  = illegal;
        end else if (illegal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            err_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            err_sticky_q <= err_sticky_d;
            err_pend_q   <= err_pend_d;
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign err_sticky = err_sticky_q;
    assign stb_empty  = (stb_count == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Bench for mem_req_sequencer: directed scenarios with literal expectations,
// then randomized traffic against a queue-based behavioural model.
module tb_mem_req_sequencer;

    localparam int STB_DEPTH = 2;
    localparam int PTR_W     = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_rd, req_wr;
    logic [15:0] req_addr, req_wdata;
    logic        req_stall, rsp_valid, rsp_err, err_sticky, stb_empty;
    logic [15:0] rsp_data, mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, mem_done, mem_stall, mem_err;

    always #5 clk = ~clk;

    mem_req_sequencer #(.STB_DEPTH(STB_DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_stall(req_stall),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .err_sticky(err_sticky), .stb_empty(stb_empty),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall), .mem_err(mem_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: store buffer as a queue, responses as a queue.
    typedef struct packed { logic [15:0] a; logic [15:0] d; } ent_t;
    typedef struct packed { logic [15:0] d; logic e; } rsp_t;
    ent_t stb[$];
    rsp_t rq[$];
    int   mode;   // 0 idle, 1 load outstanding, 2 drain outstanding
    logic e_mem_rd, e_mem_wr, e_rsp_valid, e_rsp_err, e_sticky, e_stall, e_empty;
    logic [15:0] e_mem_addr, e_mem_wdata, e_rsp_data;

    logic        cur_valid, cur_rd, cur_wr;
    logic [15:0] cur_addr, cur_wdata;
    int          fixed_lat = -1;
    int          fixed_err = -1;
    logic [15:0] fixed_rdata = 16'h0000;
    int          lat_cnt;
    logic        last_stall;

    task automatic model_reset();
        stb.delete();
        rq.delete();
        mode = 0;
        e_mem_rd = 0; e_mem_wr = 0; e_rsp_valid = 0; e_rsp_err = 0; e_sticky = 0;
        e_mem_addr = 0; e_mem_wdata = 0; e_rsp_data = 0;
        lat_cnt = 0; last_stall = 0;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] d);
        cur_valid = v; cur_rd = rd; cur_wr = wr; cur_addr = a; cur_wdata = d;
    endtask

    function automatic int new_lat();
        return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    endfunction

    task automatic step_cycle();
        logic ill, ld, st, pend, pop, ldst, ststall, hit;
        logic [15:0] hd;
        rsp_t r;
        @(negedge clk);
        chk("mem_rd", 16'(mem_rd), 16'(e_mem_rd));
        chk("mem_wr", 16'(mem_wr), 16'(e_mem_wr));
        if (e_mem_rd || e_mem_wr) chk("mem_addr", mem_addr, e_mem_addr);
        if (e_mem_wr) chk("mem_wdata", mem_wdata, e_mem_wdata);
        chk("rsp_valid", 16'(rsp_valid), 16'(e_rsp_valid));
        if (e_rsp_valid) begin
            chk("rsp_data", rsp_data, e_rsp_data);
            chk("rsp_err", 16'(rsp_err), 16'(e_rsp_err));
        end
        chk("err_sticky", 16'(err_sticky), 16'(e_sticky));

        req_valid = cur_valid; req_rd = cur_rd; req_wr = cur_wr;
        req_addr = cur_addr; req_wdata = cur_wdata;
        mem_stall = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        mem_err   = 1'($urandom_range(0, 1));
        mem_done  = 1'b0;
        if (mode != 0) begin
            if (lat_cnt == 0) begin
                mem_done = 1'b1;
                if (fixed_lat >= 0) mem_rdata = fixed_rdata;
                mem_err = (fixed_err >= 0) ? fixed_err[0] : ($urandom_range(0, 7) == 0);
            end else begin
                lat_cnt--;
            end
        end
        #1;

        ill  = cur_valid && ((cur_rd == cur_wr) || cur_addr[0]);
        ld   = cur_valid && !ill && cur_rd;
        st   = cur_valid && !ill && cur_wr;
        pend = (rq.size() > 0);
        pop  = (mode == 2) && mem_done;
        ldst = ld && ((mode != 0) || pend);
        ststall = st && (stb.size() == STB_DEPTH) && !pop;
        e_stall = ldst || ststall;
        e_empty = (stb.size() == 0) && (mode == 0);
        chk("req_stall", 16'(req_stall), 16'(e_stall));
        chk("stb_empty", 16'(stb_empty), 16'(e_empty));

        hit = 0; hd = 0;
        for (int i = stb.size() - 1; i >= 0; i--) begin
            if (stb[i].a == cur_addr) begin hit = 1; hd = stb[i].d; break; end
        end

        if (mode == 0) begin
            if (ld && !ldst) begin
                if (hit) rq.push_front('{d: hd, e: 1'b0});
                else begin
                    mode = 1; e_mem_rd = 1; e_mem_addr = cur_addr; lat_cnt = new_lat();
                end
            end else if (stb.size() > 0) begin
                mode = 2; e_mem_wr = 1; e_mem_addr = stb[0].a; e_mem_wdata = stb[0].d;
                lat_cnt = new_lat();
            end
        end else if (mode == 1 && mem_done) begin
            rq.push_front('{d: mem_rdata, e: mem_err});
            mode = 0; e_mem_rd = 0;
        end else if (mode == 2 && mem_done) begin
            void'(stb.pop_front());
            e_sticky = e_sticky | mem_err;
            mode = 0; e_mem_wr = 0;
        end
        if (ill) rq.push_back('{d: 16'h0000, e: 1'b1});
        if (st && !ststall) stb.push_back('{a: cur_addr, d: cur_wdata});

        if (rq.size() > 0) begin
            r = rq.pop_front();
            e_rsp_valid = 1; e_rsp_data = r.d; e_rsp_err = r.e;
        end else begin
            e_rsp_valid = 0; e_rsp_data = 0; e_rsp_err = 0;
        end
        last_stall = e_stall;
    endtask

    task automatic wait_drained();
        bit ok = 0;
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            if (stb.size() == 0 && mode == 0 && rq.size() == 0) begin ok = 1; break; end
            step_cycle();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drain_timeout actual=busy expected=idle t=%0t", $time);
        end
    endtask

    task automatic gen_random();
        logic [15:0] tab [4];
        int r;
        tab[0] = 16'h0010; tab[1] = 16'h0012; tab[2] = 16'h0020; tab[3] = 16'h0030;
        r = int'($urandom_range(0, 99));
        if (r < 30)      drive(0, 0, 0, 16'($urandom), 16'($urandom));
        else if (r < 60) drive(1, 0, 1, tab[$urandom_range(0, 3)], 16'($urandom));
        else if (r < 88) drive(1, 1, 0, tab[$urandom_range(0, 3)], 16'($urandom));
        else if (r < 93) drive(1, 1, 0, tab[$urandom_range(0, 3)] | 16'h0001, 0);
        else if (r < 97) drive(1, 1, 1, tab[$urandom_range(0, 3)], 0);
        else             drive(1, 0, 0, tab[$urandom_range(0, 3)], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 0; req_rd = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
        mem_rdata = 0; mem_done = 0; mem_stall = 0; mem_err = 0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mem_wr", 16'(mem_wr), 16'h0);
        chk("rst_stb_empty", 16'(stb_empty), 16'h1);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);

        // Single store drains two cycles later and holds until done.
        fixed_lat = 2; fixed_err = 0;
        drive(1, 0, 1, 16'h0010, 16'hBEEF); step_cycle();
        chk("a_stall", 16'(req_stall), 16'h0);
        drive(0, 0, 0, 0, 0); step_cycle();
        chk("a_wr_c1", 16'(mem_wr), 16'h0);
        step_cycle();
        chk("a_wr_c2", 16'(mem_wr), 16'h1);
        chk("a_addr", mem_addr, 16'h0010);
        chk("a_data", mem_wdata, 16'hBEEF);
        step_cycle(); step_cycle();
        chk("a_wr_done", 16'(mem_wr), 16'h1);
        step_cycle();
        chk("a_wr_low", 16'(mem_wr), 16'h0);
        chk("a_empty", 16'(stb_empty), 16'h1);

        // Full buffer: third store waits for the drain pop.
        drive(1, 0, 1, 16'h0010, 16'h1111); step_cycle();
        drive(1, 0, 1, 16'h0012, 16'h2222); step_cycle();
        drive(1, 0, 1, 16'h0014, 16'h3333); step_cycle();
        chk("b_stall", 16'(req_stall), 16'h1);
        step_cycle(); step_cycle();
        chk("b_accept", 16'(req_stall), 16'h0);
        drive(0, 0, 0, 0, 0); step_cycle(); step_cycle();
        chk("b_order", mem_wdata, 16'h2222);
        wait_drained();

        // Forwarding from the buffer.
        drive(1, 0, 1, 16'h0020, 16'h1234); step_cycle();
        drive(1, 1, 0, 16'h0020, 0); step_cycle();
        drive(0, 0, 0, 0, 0); step_cycle();
        chk("c_rsp_valid", 16'(rsp_valid), 16'h1);
        chk("c_rsp_data", rsp_data, 16'h1234);
        chk("c_no_rd", 16'(mem_rd), 16'h0);
        wait_drained();

        // Load miss has priority over a pending drain.
        fixed_lat = 3; fixed_rdata = 16'hCAFE;
        drive(1, 0, 1, 16'h0050, 16'h5555); step_cycle();
        drive(1, 1, 0, 16'h0040, 0); step_cycle();
        drive(0, 0, 0, 0, 0); step_cycle();
        chk("d_rd_c2", 16'(mem_rd), 16'h1);
        chk("d_wr_c2", 16'(mem_wr), 16'h0);
        step_cycle(); step_cycle(); step_cycle();
        chk("d_rd_c5", 16'(mem_rd), 16'h1);
        step_cycle();
        chk("d_rsp_valid", 16'(rsp_valid), 16'h1);
        chk("d_rsp_data", rsp_data, 16'hCAFE);
        chk("d_rd_low", 16'(mem_rd), 16'h0);
        step_cycle();
        chk("d_drain", 16'(mem_wr), 16'h1);
        wait_drained();

        // Illegal requests.
        drive(1, 1, 0, 16'h0003, 0); step_cycle();
        drive(1, 1, 1, 16'h0040, 0); step_cycle();
        chk("e_mis_err", 16'(rsp_err), 16'h1);
        chk("e_mis_rd", 16'(mem_rd), 16'h0);
        drive(0, 0, 0, 0, 0); step_cycle();
        chk("e_both_err", 16'(rsp_err), 16'h1);
        chk("e_both_wr", 16'(mem_wr), 16'h0);
        wait_drained();

        // Memory error during a drain is sticky.
        fixed_lat = 0; fixed_err = 1;
        drive(1, 0, 1, 16'h0030, 16'h7777); step_cycle();
        drive(0, 0, 0, 0, 0); step_cycle(); step_cycle(); step_cycle();
        chk("f_sticky", 16'(err_sticky), 16'h1);
        fixed_err = 0;
        step_cycle(); step_cycle();
        chk("f_sticky_hold", 16'(err_sticky), 16'h1);

        // Asynchronous reset in the middle of a load.
        fixed_lat = 3;
        wait_drained();
        drive(1, 1, 0, 16'h0060, 0); step_cycle();
        drive(0, 0, 0, 0, 0); step_cycle();
        chk("g_rd_before", 16'(mem_rd), 16'h1);
        rst = 1'b1;
        req_valid = 0; mem_done = 0;
        #1;
        chk("g_rd", 16'(mem_rd), 16'h0);
        chk("g_addr", mem_addr, 16'h0000);
        chk("g_sticky", 16'(err_sticky), 16'h0);
        chk("g_empty", 16'(stb_empty), 16'h1);
        chk("g_rsp", 16'(rsp_valid), 16'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic; the pipeline holds a stalled request.
        fixed_lat = -1; fixed_err = -1;
        for (int n = 0; n < 3000; n++) begin
            if (!last_stall) gen_random();
            step_cycle();
        end
        wait_drained();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
